// File: rtl/mmi_arbiter.sv
// Two-requester round-robin arbiter onto a single MMI register-file port.
// Grants are locked per transaction; a stalled slave gets an error completion after TIMEOUT cycles.
module mmi_arbiter #(
    parameter int          ADDR_W   = 3,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [3:0]        m0_wstrb,
    input  logic [31:0]       m0_wdata,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [3:0]        m1_wstrb,
    input  logic [31:0]       m1_wdata,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [31:0]       m1_rdata,
    output logic              mmi_valid,
    input  logic              mmi_ready,
    output logic [3:0]        mmi_wstrb,
    output logic [31:0]       mmi_wdata,
    output logic [ADDR_W-1:0] mmi_addr,
    input  logic [31:0]       mmi_rdata,
    output logic [1:0]        grant,
    output logic              err_o
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      state, state_nxt;
    logic        last_owner, last_owner_nxt;  // 0 = m0, 1 = m1
    logic [7:0]  wait_cnt;
    logic        own1, granted, req_valid, hit, tout;
    logic [31:0] rdata_c;

    assign own1      = (state == GNT1);
    assign granted   = (state != IDLE);
    assign req_valid = own1 ? m1_valid : m0_valid;
    // slave ready beats a simultaneous timeout
    assign hit       = granted && req_valid && mmi_ready;
    assign tout      = granted && req_valid && !mmi_ready && (wait_cnt == TO);
    assign rdata_c   = hit ? mmi_rdata : ERR_DATA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wait_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            if (state == IDLE)
                wait_cnt <= 8'd0;
            else if (!mmi_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        mmi_valid      = 1'b0;
        mmi_wstrb      = 4'd0;
        mmi_wdata      = 32'd0;
        mmi_addr       = '0;
        m0_ready       = 1'b0;
        m1_ready       = 1'b0;
        m0_rdata       = 32'd0;
        m1_rdata       = 32'd0;
        err_o          = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid)
                    state_nxt = last_owner ? GNT0 : GNT1;
                else if (m0_valid)
                    state_nxt = GNT0;
                else if (m1_valid)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                mmi_valid = req_valid && !tout;
                mmi_wstrb = own1 ? m1_wstrb : m0_wstrb;
                mmi_wdata = own1 ? m1_wdata : m0_wdata;
                mmi_addr  = own1 ? m1_addr  : m0_addr;
                if (!req_valid) begin
                    // requester abandoned the transaction: no completion, owner history kept
                    state_nxt = IDLE;
                end else if (hit || tout) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = own1;
                    err_o          = tout;
                    if (own1) begin
                        m1_ready = 1'b1;
                        m1_rdata = rdata_c;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = rdata_c;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            GNT0:    grant = 2'b01;
            GNT1:    grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mmi_arbiter.sv
// Directed bench for mmi_arbiter: tie alternation, single read, lock, timeout, abandon and reset cases.
module tb_mmi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, mmi_wstrb;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mmi_wdata, mmi_rdata;
    logic [2:0]  m0_addr, m1_addr, mmi_addr;
    logic        mmi_valid, mmi_ready, err_o;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    mmi_arbiter #(.ADDR_W(3), .TIMEOUT(15), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
        .mmi_valid(mmi_valid), .mmi_ready(mmi_ready), .mmi_wstrb(mmi_wstrb),
        .mmi_wdata(mmi_wdata), .mmi_addr(mmi_addr), .mmi_rdata(mmi_rdata),
        .grant(grant), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called in an IDLE cycle; both requesters raise valid, winner completes with zero wait.
    task automatic serve_tie(input string tag, input logic [1:0] exp_g);
        m0_valid = 1'b1; m1_valid = 1'b1; mmi_ready = 1'b0;
        m0_wdata = 32'h0000_00A0; m1_wdata = 32'h0000_00B1;
        #1 chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
        cyc();
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        chk({tag, "_wdata"}, mmi_wdata, exp_g[0] ? 32'h0000_00A0 : 32'h0000_00B1);
        mmi_ready = 1'b1; mmi_rdata = 32'h0000_5555;
        #1 chk({tag, "_ready"}, 32'({m1_ready, m0_ready}), 32'(exp_g));
        cyc();
        m0_valid = 1'b0; m1_valid = 1'b0; mmi_ready = 1'b0;
        #1 chk({tag, "_after_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        m0_valid = 1'b1; m1_valid = 1'b0; mmi_ready = 1'b1;
        m0_wstrb = 4'h0; m1_wstrb = 4'h0; m0_wdata = 32'h1111_1111; m1_wdata = 32'h0;
        m0_addr = 3'd7; m1_addr = 3'd0; mmi_rdata = 32'hFFFF_FFFF;
        #12;
        // reset state: everything quiet even with requests and slave ready present
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mmi_valid", 32'(mmi_valid), 32'd0);
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_addr", 32'(mmi_addr), 32'd0);
        chk("rst_wdata", mmi_wdata, 32'd0);
        chk("rst_rdata", m0_rdata, 32'd0);
        m0_valid = 1'b0; mmi_ready = 1'b0; rst = 1'b1;
        cyc();

        // ties alternate starting with m0
        serve_tie("tie1", 2'b01);
        serve_tie("tie2", 2'b10);
        serve_tie("tie3", 2'b01);
        serve_tie("tie4", 2'b10);

        // single read, slave answers two cycles after grant
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 3'd3;
        cyc();
        chk("rd_grant", 32'(grant), 32'd1);
        chk("rd_mmi_valid", 32'(mmi_valid), 32'd1);
        chk("rd_addr", 32'(mmi_addr), 32'd3);
        chk("rd_wstrb", 32'(mmi_wstrb), 32'd0);
        chk("rd_wait1", 32'(m0_ready), 32'd0);
        cyc();
        chk("rd_wait2", 32'(m0_ready), 32'd0);
        cyc();
        mmi_ready = 1'b1; mmi_rdata = 32'h1234_5678;
        #1 chk("rd_ready", 32'(m0_ready), 32'd1);
        chk("rd_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_m1_quiet", 32'(m1_ready) | m1_rdata, 32'd0);
        chk("rd_err", 32'(err_o), 32'd0);
        cyc();
        m0_valid = 1'b0; mmi_ready = 1'b0;
        #1 chk("rd_idle", 32'(grant), 32'd0);
        chk("rd_one_pulse", 32'(m0_ready), 32'd0);

        // lock: m1 write in flight, m0 arrives and must wait
        m1_valid = 1'b1; m1_wstrb = 4'hF; m1_wdata = 32'hAAAA_5555; m1_addr = 3'd5;
        cyc();
        chk("lk_grant1", 32'(grant), 32'd2);
        m0_valid = 1'b1; m0_addr = 3'd2; m0_wstrb = 4'h3; m0_wdata = 32'h0BAD_F00D;
        cyc();
        chk("lk_held", 32'(grant), 32'd2);
        chk("lk_addr", 32'(mmi_addr), 32'd5);
        chk("lk_wstrb", 32'(mmi_wstrb), 32'hF);
        chk("lk_wdata", mmi_wdata, 32'hAAAA_5555);
        mmi_ready = 1'b1; mmi_rdata = 32'h0;
        #1 chk("lk_ready", 32'({m1_ready, m0_ready}), 32'd2);
        cyc();
        m1_valid = 1'b0; mmi_ready = 1'b0;
        #1 chk("lk_idle", 32'(grant), 32'd0);
        cyc();
        chk("lk_grant0", 32'(grant), 32'd1);
        chk("lk_addr0", 32'(mmi_addr), 32'd2);
        chk("lk_wdata0", mmi_wdata, 32'h0BAD_F00D);
        mmi_ready = 1'b1;
        #1 chk("lk_ready0", 32'(m0_ready), 32'd1);
        cyc();
        m0_valid = 1'b0; mmi_ready = 1'b0;

        // timeout: slave never ready, error completion on 16th grant cycle
        cyc();
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 3'd1; mmi_rdata = 32'h7777_7777;
        cyc();
        for (int i = 1; i <= 15; i++) begin
            chk("to_wait_ready", 32'({err_o, m0_ready}), 32'd0);
            chk("to_wait_valid", 32'(mmi_valid), 32'd1);
            cyc();
        end
        chk("to_ready", 32'(m0_ready), 32'd1);
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_mmi_valid", 32'(mmi_valid), 32'd0);
        cyc();
        m0_valid = 1'b0;
        #1 chk("to_idle", 32'({err_o, grant}), 32'd0);

        // slave ready exactly at the limit: normal completion
        m1_valid = 1'b1; m1_wstrb = 4'h0;
        cyc();
        chk("lim_grant", 32'(grant), 32'd2);
        for (int i = 1; i <= 15; i++) cyc();
        mmi_ready = 1'b1; mmi_rdata = 32'hCAFE_F00D;
        #1 chk("lim_ready", 32'(m1_ready), 32'd1);
        chk("lim_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("lim_err", 32'(err_o), 32'd0);
        chk("lim_mmi_valid", 32'(mmi_valid), 32'd1);
        cyc();
        m1_valid = 1'b0; mmi_ready = 1'b0;

        // slave ready while idle is ignored
        mmi_ready = 1'b1;
        #1 chk("idle_ready", 32'({m1_ready, m0_ready}), 32'd0);
        mmi_ready = 1'b0;

        // m0 abandons its grant: no completion, owner history stays m1
        m0_valid = 1'b1;
        cyc();
        chk("ab_grant", 32'(grant), 32'd1);
        m0_valid = 1'b0; mmi_ready = 1'b1;
        #1 chk("ab_no_ready", 32'(m0_ready), 32'd0);
        chk("ab_mmi_valid", 32'(mmi_valid), 32'd0);
        cyc();
        mmi_ready = 1'b0;
        #1 chk("ab_idle", 32'(grant), 32'd0);
        serve_tie("ab_tie", 2'b01);

        // reset during an m1 grant
        m1_valid = 1'b1;
        cyc();
        chk("rm_grant", 32'(grant), 32'd2);
        rst = 1'b0; mmi_ready = 1'b1;
        #1 chk("rm_grant_async", 32'(grant), 32'd0);
        chk("rm_mmi_valid", 32'(mmi_valid), 32'd0);
        chk("rm_no_ready", 32'(m1_ready), 32'd0);
        cyc();
        chk("rm_held", 32'({m1_ready, grant}), 32'd0);
        rst = 1'b1; m1_valid = 1'b0; mmi_ready = 1'b0;
        cyc();
        serve_tie("rm_tie", 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
